// File: rtl/fft_reorder_if.sv
// Streaming port bundle for the FFT output reorder unit: bit-reversed samples in,
// natural-order samples out with index and end-of-frame marker.
interface fft_reorder_if #(
    parameter int DW   = 17,
    parameter int LOGN = 5
);
    logic                   valid_i;
    logic signed [DW-1:0]   data_in_r;
    logic signed [DW-1:0]   data_in_i;
    logic                   valid_o;
    logic signed [DW-1:0]   data_out_r;
    logic signed [DW-1:0]   data_out_i;
    logic [LOGN-1:0]        index_o;
    logic                   last_o;

    modport master (
        output valid_i, data_in_r, data_in_i,
        input  valid_o, data_out_r, data_out_i, index_o, last_o
    );

    modport slave (
        input  valid_i, data_in_r, data_in_i,
        output valid_o, data_out_r, data_out_i, index_o, last_o
    );
endinterface

// File: rtl/fft_reorder.sv
// Ping-pong reorder buffer turning bit-reversed FFT frames into natural-order bursts;
// one bank fills while the other drains, so back-to-back frames never stall.
module fft_reorder #(
    parameter int DW   = 17,
    parameter int N    = 32,
    parameter int LOGN = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    fft_reorder_if.slave  bus
);
    localparam logic [LOGN-1:0] LAST = LOGN'(N - 1);

    typedef enum logic {R_IDLE, R_READ} rd_state_t;

    rd_state_t            state;
    rd_state_t            state_nxt;
    logic [LOGN-1:0]      wr_cnt;
    logic                 wr_bank;
    logic [LOGN-1:0]      rd_cnt;
    logic                 rd_bank;
    logic [1:0]           full;
    logic [1:0]           full_nxt;
    logic                 wr_done;
    logic                 rd_en;
    logic                 rd_done;
    logic                 other_bank;

    logic signed [DW-1:0] mem_r [2][N];
    logic signed [DW-1:0] mem_i [2][N];

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] a);
        logic [LOGN-1:0] r;
        r = '0;
        for (int b = 0; b < LOGN; b++) begin
            r[b] = a[LOGN-1-b];
        end
        return r;
    endfunction

    assign wr_done    = bus.valid_i && (wr_cnt == LAST);
    assign other_bank = ~rd_bank;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
        end else if (bus.valid_i) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (wr_done) begin
                wr_bank <= ~wr_bank;
            end
        end
    end

    // Sample storage is deliberately not reset; the full flags alone say what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && bus.valid_i) begin
            mem_r[wr_bank][bitrev(wr_cnt)] <= bus.data_in_r;
            mem_i[wr_bank][bitrev(wr_cnt)] <= bus.data_in_i;
        end
    end

    // Writer and reader always touch different banks, so set and clear never collide.
    always_comb begin
        full_nxt = full;
        if (wr_done) begin
            full_nxt[wr_bank] = 1'b1;
        end
        if (rd_done) begin
            full_nxt[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full <= 2'b00;
        end else begin
            full <= full_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= R_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            R_IDLE: begin
                if (full[rd_bank]) begin
                    state_nxt = R_READ;
                end
            end
            R_READ: begin
                if (rd_done && !(full[other_bank] || (wr_done && (wr_bank == other_bank)))) begin
                    state_nxt = R_IDLE;
                end
            end
            default: state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        rd_en   = (state == R_READ);
        rd_done = rd_en && (rd_cnt == LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_cnt  <= '0;
            rd_bank <= 1'b0;
        end else begin
            if (rd_en) begin
                rd_cnt <= rd_cnt + 1'b1;
            end else begin
                rd_cnt <= '0;
            end
            if (rd_done) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

    // Data and index hold their last values between bursts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.valid_o    <= 1'b0;
            bus.last_o     <= 1'b0;
            bus.index_o    <= '0;
            bus.data_out_r <= '0;
            bus.data_out_i <= '0;
        end else begin
            bus.valid_o <= rd_en;
            bus.last_o  <= rd_done;
            if (rd_en) begin
                bus.index_o    <= rd_cnt;
                bus.data_out_r <= mem_r[rd_bank][rd_cnt];
                bus.data_out_i <= mem_i[rd_bank][rd_cnt];
            end
        end
    end
endmodule
